// File: rtl/mux_tree_pipe.sv
// Pipelined N:1 channel mux built from registered 4:1 levels.
// Select is external or a round-robin scan counter.
module mux_tree_pipe #(
  parameter int WIDTH  = 8,
  parameter int LEVELS = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [(4**LEVELS)*WIDTH-1:0]  din,
  input  logic [2*LEVELS-1:0]           sel,
  input  logic                          mode,
  input  logic                          in_valid,
  output logic [WIDTH-1:0]              y,
  output logic [2*LEVELS-1:0]           y_sel,
  output logic                          out_valid,
  output logic                          out_last
);

  localparam int NCH   = 4**LEVELS;
  localparam int SW    = 2*LEVELS;
  localparam int NNODE = (NCH-1)/3;

  // Nodes of every level live in one array; level j starts at base(j).
  function automatic int base(input int lvl);
    int acc;
    acc = 0;
    for (int i = 0; i < lvl; i++)
      acc += NCH >> (2*(i+1));
    return acc;
  endfunction

  logic [SW-1:0]    scan_cnt;
  logic [SW-1:0]    eff_sel;
  logic [WIDTH-1:0] node  [NNODE];
  logic [SW-1:0]    sel_q [LEVELS];
  logic [LEVELS-1:0] vld_q;
  logic [LEVELS-1:0] lst_q;

  assign eff_sel = mode ? scan_cnt : sel;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scan_cnt <= '0;
    end else if (!mode) begin
      scan_cnt <= '0;
    end else if (in_valid) begin
      scan_cnt <= scan_cnt + SW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q <= '0;
      lst_q <= '0;
    end else begin
      vld_q[0] <= in_valid;
      lst_q[0] <= in_valid & mode & (scan_cnt == '1);
      for (int j = 1; j < LEVELS; j++) begin
        vld_q[j] <= vld_q[j-1];
        lst_q[j] <= lst_q[j-1];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      node  <= '{default: '0};
      sel_q <= '{default: '0};
    end else begin
      if (in_valid) begin
        sel_q[0] <= eff_sel;
        for (int g = 0; g < NCH/4; g++)
          node[g] <= din[(4*g + int'(eff_sel[1:0]))*WIDTH +: WIDTH];
      end
      // Each upper level advances only behind a valid sample.
      for (int j = 1; j < LEVELS; j++) begin
        if (vld_q[j-1]) begin
          sel_q[j] <= sel_q[j-1];
          for (int g = 0; g < (NCH >> (2*(j+1))); g++)
            node[base(j)+g] <=
              node[base(j-1) + 4*g + int'(sel_q[j-1][2*j +: 2])];
        end
      end
    end
  end

  assign y         = node[NNODE-1];
  assign y_sel     = sel_q[LEVELS-1];
  assign out_valid = vld_q[LEVELS-1];
  assign out_last  = vld_q[LEVELS-1] & lst_q[LEVELS-1];

endmodule
